// File: rtl/arm_vec_pkg.sv
// Shared types for the vector execution unit: op encoding, FSM states, beat math.
// Optional build macro VEC_SAT_EN turns codes 6/7 into signed saturating add/sub.
package arm_vec_pkg;

  typedef enum logic [2:0] {
    OP_VADD  = 3'd0,
    OP_VSUB  = 3'd1,
    OP_VAND  = 3'd2,
    OP_VORR  = 3'd3,
    OP_VDUP  = 3'd4,
    OP_VINS  = 3'd5,
`ifdef VEC_SAT_EN
    OP_VQSUB = 3'd6,
    OP_VQADD = 3'd7
`else
    OP_VEXT  = 3'd6
`endif
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  function automatic int beats(input int lanes, input int lpc);
    return (lanes + lpc - 1) / lpc;
  endfunction

  // Lane-wise ops sweep the whole vector; everything else takes a single beat.
  function automatic logic is_lane_op(input op_e op);
    case (op)
      OP_VADD, OP_VSUB, OP_VAND, OP_VORR, OP_VDUP: return 1'b1;
`ifdef VEC_SAT_EN
      OP_VQADD, OP_VQSUB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_vec_lane_alu.sv
// Single-lane combinational ALU; one instance per lane processed in a beat.
// Saturating add/sub exist only when VEC_SAT_EN is defined.
module arm_vec_lane_alu
  import arm_vec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  op_e                   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] scalar_i,
  output logic [DATA_WIDTH-1:0] y_o
);

`ifdef VEC_SAT_EN
  localparam logic signed [DATA_WIDTH:0] SMAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SMIN = {2'b11, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] v);
    if (v > SMAX) return SMAX[DATA_WIDTH-1:0];
    if (v < SMIN) return SMIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH:0] a_s, b_s;
  assign a_s = $signed({a_i[DATA_WIDTH-1], a_i});
  assign b_s = $signed({b_i[DATA_WIDTH-1], b_i});
`endif

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_VADD:  y_o = a_i + b_i;
      OP_VSUB:  y_o = a_i - b_i;
      OP_VAND:  y_o = a_i & b_i;
      OP_VORR:  y_o = a_i | b_i;
      OP_VDUP:  y_o = scalar_i;
`ifdef VEC_SAT_EN
      OP_VQADD: y_o = sat(a_s + b_s);
      OP_VQSUB: y_o = sat(a_s - b_s);
`endif
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/arm_vec_unit.sv
// Multi-cycle vector execution unit: NUM_VREGS x NUM_LANES register file, LANES_PER_CYCLE lanes per beat.
// Build macro VEC_SAT_EN selects saturating ops on codes 6/7 (otherwise 6 = VEXT, 7 reserved).
module arm_vec_unit
  import arm_vec_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_LANES       = 5,
  parameter int NUM_VREGS       = 4,
  parameter int LANES_PER_CYCLE = 1,
  localparam int VIW = $clog2(NUM_VREGS),
  localparam int LIW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [2:0]                      op,
  input  logic [VIW-1:0]                  vd,
  input  logic [VIW-1:0]                  vn,
  input  logic [VIW-1:0]                  vm,
  input  logic [DATA_WIDTH-1:0]           scalar_in,
  input  logic [LIW-1:0]                  lane_idx,
  input  logic [VIW-1:0]                  rd_vreg,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH-1:0]           scalar_out,
  output logic                            lane_err,
  output logic [NUM_LANES*DATA_WIDTH-1:0] vec_out
);

  localparam int BEATS = beats(NUM_LANES, LANES_PER_CYCLE);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [VIW-1:0]        vd_q, vn_q, vm_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [LIW-1:0]        lane_q;
  logic [BW-1:0]         beat_q;
  logic [DATA_WIDTH-1:0] scalar_out_q;
  logic                  lane_err_q;
  logic [DATA_WIDTH-1:0] vreg_q [NUM_VREGS][NUM_LANES];

  logic                  last_beat, lane_ok;
  logic                  vld [LANES_PER_CYCLE];
  logic [LIW-1:0]        sel [LANES_PER_CYCLE];
  logic [DATA_WIDTH-1:0] y   [LANES_PER_CYCLE];

  assign last_beat = !is_lane_op(op_q) || (int'(beat_q) == BEATS - 1);
  assign lane_ok   = int'(lane_q) < NUM_LANES;

  // Lanes of the current beat; the tail of a partial final beat is masked off.
  always_comb begin
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      vld[j] = (int'(beat_q) * LANES_PER_CYCLE + j) < NUM_LANES;
      sel[j] = vld[j] ? LIW'(int'(beat_q) * LANES_PER_CYCLE + j) : '0;
    end
  end

  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    arm_vec_lane_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op_i     (op_q),
      .a_i      (vreg_q[vn_q][sel[g]]),
      .b_i      (vreg_q[vm_q][sel[g]]),
      .scalar_i (scalar_q),
      .y_o      (y[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EXEC;
      ST_EXEC: if (last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      scalar_out_q <= '0;
      lane_err_q   <= 1'b0;
      for (int r = 0; r < NUM_VREGS; r++)
        for (int l = 0; l < NUM_LANES; l++)
          vreg_q[r][l] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (start) begin
          op_q       <= op_e'(op);
          vd_q       <= vd;
          vn_q       <= vn;
          vm_q       <= vm;
          scalar_q   <= scalar_in;
          lane_q     <= lane_idx;
          beat_q     <= '0;
          lane_err_q <= 1'b0;
        end
        ST_EXEC: begin
          beat_q <= beat_q + BW'(1);
          // Reads see pre-beat values, so in-place vd==vn/vm needs no special handling.
          if (is_lane_op(op_q)) begin
            for (int j = 0; j < LANES_PER_CYCLE; j++)
              if (vld[j]) vreg_q[vd_q][sel[j]] <= y[j];
          end else if (op_q == OP_VINS) begin
            if (lane_ok) vreg_q[vd_q][lane_q] <= scalar_q;
            else         lane_err_q <= 1'b1;
          end
`ifndef VEC_SAT_EN
          else if (op_q == OP_VEXT) begin
            if (lane_ok) scalar_out_q <= vreg_q[vn_q][lane_q];
            else         lane_err_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign scalar_out = scalar_out_q;
  assign lane_err   = lane_err_q;

  always_comb begin
    vec_out = '0;
    for (int l = 0; l < NUM_LANES; l++)
      vec_out[l*DATA_WIDTH +: DATA_WIDTH] = vreg_q[rd_vreg][l];
  end

endmodule

// File: tb/tb_arm_vec_unit.sv
// Bench for arm_vec_unit: two instances (1 and 2 lanes per beat) share stimulus and one vector model.
module tb_arm_vec_unit;

  localparam int NL = 5;
  localparam int NV = 4;
  localparam int C_VADD = 0, C_VSUB = 1, C_VAND = 2, C_VORR = 3, C_VDUP = 4, C_VINS = 5, C_OP6 = 6, C_OP7 = 7;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [1:0]   vd, vn, vm, rd_vreg;
  logic [31:0]  scalar_in;
  logic [2:0]   lane_idx;
  logic         busy1, done1, err1, busy2, done2, err2;
  logic [31:0]  so1, so2;
  logic [159:0] vo1, vo2;

  always #5 clk = ~clk;

  arm_vec_unit #(.DATA_WIDTH(32), .NUM_LANES(NL), .NUM_VREGS(NV), .LANES_PER_CYCLE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .vd(vd), .vn(vn), .vm(vm),
    .scalar_in(scalar_in), .lane_idx(lane_idx), .rd_vreg(rd_vreg),
    .busy(busy1), .done(done1), .scalar_out(so1), .lane_err(err1), .vec_out(vo1));

  arm_vec_unit #(.DATA_WIDTH(32), .NUM_LANES(NL), .NUM_VREGS(NV), .LANES_PER_CYCLE(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .op(op), .vd(vd), .vn(vn), .vm(vm),
    .scalar_in(scalar_in), .lane_idx(lane_idx), .rd_vreg(rd_vreg),
    .busy(busy2), .done(done2), .scalar_out(so2), .lane_err(err2), .vec_out(vo2));

  int passed = 0;
  int total  = 0;

  logic [31:0] m [NV][NL];
  logic [31:0] m_so;
  logic        m_err;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int r = 0; r < NV; r++)
      for (int l = 0; l < NL; l++)
        m[r][l] = 32'h0;
    m_so  = 32'h0;
    m_err = 1'b0;
  endtask

  function automatic bit model_is_lane(input int o);
`ifdef VEC_SAT_EN
    return (o <= C_VDUP) || (o == C_OP6) || (o == C_OP7);
`else
    return (o <= C_VDUP);
`endif
  endfunction

  function automatic logic [31:0] clamp32(input longint t);
    longint c;
    c = t;
    if (c > 64'sd2147483647)  c = 64'sd2147483647;
    if (c < -64'sd2147483648) c = -64'sd2147483648;
    return c[31:0];
  endfunction

  // Spec-level effect of one instruction on the architectural state.
  task automatic model_op(input int o, input int d, input int n, input int mm, input logic [31:0] s, input int li);
    logic [31:0] r [NL];
    logic [31:0] a, b;
    m_err = 1'b0;
    if (model_is_lane(o)) begin
      for (int l = 0; l < NL; l++) begin
        a = m[n][l];
        b = m[mm][l];
        case (o)
          C_VADD: r[l] = a + b;
          C_VSUB: r[l] = a - b;
          C_VAND: r[l] = a & b;
          C_VORR: r[l] = a | b;
          C_VDUP: r[l] = s;
          C_OP6:  r[l] = clamp32(longint'($signed(a)) - longint'($signed(b)));
          default: r[l] = clamp32(longint'($signed(a)) + longint'($signed(b)));
        endcase
      end
      for (int l = 0; l < NL; l++) m[d][l] = r[l];
    end else if (o == C_VINS) begin
      if (li < NL) m[d][li] = s;
      else m_err = 1'b1;
    end
`ifndef VEC_SAT_EN
    else if (o == C_OP6) begin
      if (li < NL) m_so = m[n][li];
      else m_err = 1'b1;
    end
`endif
  endtask

  task automatic check_regs(input string tag);
    logic [159:0] e;
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      rd_vreg = 2'(r);
      #1;
      for (int l = 0; l < NL; l++) e[l*32 +: 32] = m[r][l];
      check(tag, vo1, e);
      check(tag, vo2, e);
    end
  endtask

  // Issue one instruction, scramble the inputs after acceptance, then wait (bounded) for both dones.
  task automatic issue(input int o, input int d, input int n, input int mm, input logic [31:0] s,
                       input int li, input bit poke);
    int  n1, n2, e1, e2;
    bit  bad;
    @(negedge clk);
    op = 3'(o); vd = 2'(d); vn = 2'(n); vm = 2'(mm); scalar_in = s; lane_idx = 3'(li);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); vd = 2'($urandom); vn = 2'($urandom); vm = 2'($urandom);
    scalar_in = $urandom; lane_idx = 3'($urandom);
    model_op(o, d, n, mm, s, li);
    n1 = -1; n2 = -1; bad = 1'b0;
    for (int k = 1; k <= 20 && (n1 < 0 || n2 < 0); k++) begin
      @(negedge clk);
      if (poke && k == 1) begin
        start = 1'b1; op = 3'(C_VDUP); vd = 2'd1; scalar_in = 32'h9;
      end
      if (poke && k == 2) start = 1'b0;
      if (n1 < 0) begin
        if (busy1 !== 1'b1) bad = 1'b1;
        if (done1 === 1'b1) n1 = k;
      end
      if (n2 < 0) begin
        if (busy2 !== 1'b1) bad = 1'b1;
        if (done2 === 1'b1) n2 = k;
      end
    end
    e1 = model_is_lane(o) ? (NL + 0) / 1 + 1 : 2;
    e2 = model_is_lane(o) ? (NL + 1) / 2 + 1 : 2;
    check("latency_lpc1", n1, e1);
    check("latency_lpc2", n2, e2);
    check("busy_until_done", bad, 0);
    check("lane_err1", err1, m_err);
    check("lane_err2", err2, m_err);
    check("scalar_out1", so1, m_so);
    check("scalar_out2", so2, m_so);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; vd = '0; vn = '0; vm = '0;
    scalar_in = '0; lane_idx = '0; rd_vreg = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy1", busy1, 0);
    check("rst_busy2", busy2, 0);
    check("rst_done1", done1, 0);
    check("rst_done2", done2, 0);
    check("rst_so1", so1, 0);
    check("rst_err1", err1, 0);
    check_regs("rst_vregs");

    issue(C_VDUP, 1, 0, 0, 32'h11, 0, 0);
    check_regs("vdup");

    issue(C_VDUP, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    issue(C_VDUP, 2, 0, 0, 32'h1, 0, 0);
    issue(C_VADD, 0, 1, 2, 32'h0, 0, 0);
    check_regs("vadd_wrap");

    for (int l = 0; l < NL; l++) issue(C_VINS, 3, 0, 0, $urandom, l, 0);
    issue(C_VSUB, 3, 3, 2, 32'h0, 0, 0);
    check_regs("vsub_inplace");

    for (int i = 0; i < 10; i++)
      issue($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom, 0, 0);
    check_regs("random_ops");

    issue(C_VINS, 0, 0, 0, 32'hABCD, 3, 0);
`ifndef VEC_SAT_EN
    issue(C_OP6, 0, 0, 0, 32'h0, 3, 0);
    check("vext_value", so1, 32'hABCD);
    issue(C_OP6, 0, 0, 0, 32'h0, 7, 0);
    check("vext_oob_err", err1, 1);
    check("vext_oob_hold", so2, 32'hABCD);
`endif
    issue(C_VINS, 0, 0, 0, 32'h1234, 6, 0);
    issue(C_VINS, 0, 0, 0, 32'h5678, 1, 0);
    check_regs("vins");

    issue(C_VDUP, 1, 0, 0, 32'h7FFF_FFF0, 0, 0);
    issue(C_VDUP, 2, 0, 0, 32'h20, 0, 0);
    issue(C_OP7, 0, 1, 2, 32'h0, 0, 0);
    check_regs("op7");

    issue(C_VDUP, 0, 0, 0, 32'h5, 0, 1);
    @(negedge clk);
    check("no_queue_busy1", busy1, 0);
    check("no_queue_busy2", busy2, 0);
    check_regs("start_ignored");

    // Abort a VADD during its third beat.
    @(negedge clk);
    op = 3'(C_VADD); vd = 2'd0; vn = 2'd1; vm = 2'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy1", busy1, 0);
    check("abort_busy2", busy2, 0);
    check("abort_done1", done1, 0);
    check("abort_done2", done2, 0);
    reset = 1'b0;
    start = 1'b0;
    model_clear();
    check_regs("abort_vregs");
    repeat (3) @(negedge clk);
    check("abort_no_done1", done1, 0);
    check("abort_idle2", busy2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
